hazard_scoreboard: RTL and testbench

//  Tracks the in-flight destination registers of the EXE, MEM and WB stages.

---
 rtl/hazard_scoreboard.sv | 134 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks the destination registers in flight in EXE, MEM and WB, feeds the
//   forwarding unit with per-stage dest/write-back info, and raises
//   hazard_stall when a read-after-write hazard cannot be forwarded.
// Ports
//   clk, rst              rising-edge clock, asynchronous active-low reset
//   id_*                  decoded ID-stage instruction (sources, dest, wb, load)
//   enable_forward_unit   1 = forwarding available, 0 = stall on any RAW hit
//   freeze                memory wait; whole pipeline (and counter) holds
//   flush                 squash the instruction entering EXE
//   hazard_stall          combinational stall request to PC and IF/ID
//   {exe,mem,wb}_reg_*    registered per-stage destination and write enable
//   stall_count           saturating count of stalled, non-frozen cycles
module hazard_scoreboard #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] id_reg_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              enable_forward_unit,
  input  logic              freeze,
  input  logic              flush,
  output logic              hazard_stall,
  output logic [REG_AW-1:0] exe_reg_dest,
  output logic              exe_reg_wb,
  output logic [REG_AW-1:0] mem_reg_dest,
  output logic              mem_reg_wb,
  output logic [REG_AW-1:0] wb_reg_dest,
  output logic              wb_reg_wb,
  output logic [CNT_W-1:0]  stall_count
);

  // EXE entry keeps the load flag for load-use detection.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              wb;
    logic              mem_read;
  } exe_entry_t;

  // Past EXE the load flag no longer influences any decision, so it is dropped.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              wb;
  } late_entry_t;

  exe_entry_t       exe_q;
  late_entry_t      mem_q;
  late_entry_t      wb_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic exe_wr;
  logic mem_wr;
  logic wb_wr;
  logic src1_live;
  logic src2_live;
  logic hit_exe;
  logic hit_mem;

  // Per-stage "real register write" and RAW match against the ID sources.
  always_comb begin
    exe_wr       = 1'b0;
    mem_wr       = 1'b0;
    wb_wr        = 1'b0;
    src1_live    = 1'b0;
    src2_live    = 1'b0;
    hit_exe      = 1'b0;
    hit_mem      = 1'b0;
    hazard_stall = 1'b0;

    // Writes to $0 are discarded by the register file, so they never count.
    exe_wr = exe_q.valid & exe_q.wb & (exe_q.dest != '0);
    mem_wr = mem_q.valid & mem_q.wb & (mem_q.dest != '0);
    wb_wr  = wb_q.valid  & wb_q.wb  & (wb_q.dest  != '0);

    src1_live = (id_src1 != '0);
    src2_live = id_two_src & (id_src2 != '0);

    hit_exe = exe_wr & ((src1_live & (id_src1 == exe_q.dest)) |
                        (src2_live & (id_src2 == exe_q.dest)));
    hit_mem = mem_wr & ((src1_live & (id_src1 == mem_q.dest)) |
                        (src2_live & (id_src2 == mem_q.dest)));

    // WB is never a hazard: the register file writes before it is read.
    if (id_valid) begin
      if (enable_forward_unit) begin
        hazard_stall = hit_exe & exe_q.mem_read;
      end else begin
        hazard_stall = hit_exe | hit_mem;
      end
    end
  end

  // Pipeline advance: freeze holds everything, stall/flush inject one bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_q       <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else if (!freeze) begin
      if (flush || hazard_stall) begin
        exe_q <= '0;
      end else begin
        exe_q <= '{valid:    id_valid,
                   dest:     id_reg_dest,
                   wb:       id_wb_en,
                   mem_read: id_mem_read};
      end
      mem_q <= '{valid: exe_q.valid, dest: exe_q.dest, wb: exe_q.wb};
      wb_q  <= mem_q;
      if (hazard_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign exe_reg_dest = exe_q.dest;
  assign exe_reg_wb   = exe_wr;
  assign mem_reg_dest = mem_q.dest;
  assign mem_reg_wb   = mem_wr;
  assign wb_reg_dest  = wb_q.dest;
  assign wb_reg_wb    = wb_wr;
  assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus randomized traffic, checked against a stage-list
// reference model of the scoreboard rules.
module tb_hazard_scoreboard;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CMAX   = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_two_src;
  logic [REG_AW-1:0] id_reg_dest;
  logic              id_wb_en;
  logic              id_mem_read;
  logic              enable_forward_unit;
  logic              freeze;
  logic              flush;
  logic              hazard_stall;
  logic [REG_AW-1:0] exe_reg_dest;
  logic              exe_reg_wb;
  logic [REG_AW-1:0] mem_reg_dest;
  logic              mem_reg_wb;
  logic [REG_AW-1:0] wb_reg_dest;
  logic              wb_reg_wb;
  logic [CNT_W-1:0]  stall_count;

  hazard_scoreboard #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .id_valid            (id_valid),
    .id_src1             (id_src1),
    .id_src2             (id_src2),
    .id_two_src          (id_two_src),
    .id_reg_dest         (id_reg_dest),
    .id_wb_en            (id_wb_en),
    .id_mem_read         (id_mem_read),
    .enable_forward_unit (enable_forward_unit),
    .freeze              (freeze),
    .flush               (flush),
    .hazard_stall        (hazard_stall),
    .exe_reg_dest        (exe_reg_dest),
    .exe_reg_wb          (exe_reg_wb),
    .mem_reg_dest        (mem_reg_dest),
    .mem_reg_wb          (mem_reg_wb),
    .wb_reg_dest         (wb_reg_dest),
    .wb_reg_wb           (wb_reg_wb),
    .stall_count         (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pipe[0]=EXE, pipe[1]=MEM, pipe[2]=WB.
  typedef struct {
    bit          v;
    int unsigned dest;
    bit          wb;
    bit          ld;
  } ment_t;

  ment_t       pipe [3];
  ment_t       nxt  [3];
  int unsigned m_cnt;
  int unsigned n_cnt;

  function automatic bit writes(ment_t e);
    return e.v && e.wb && (e.dest != 0);
  endfunction

  // A source is blocked by the stages still inside the hazard window:
  // with forwarding only a load in EXE, without it any writer in EXE or MEM.
  function automatic bit model_stall();
    int unsigned srcs [$];
    int          window;
    bit          s;
    s = 0;
    if (!id_valid) return 0;
    srcs.push_back(int'(id_src1));
    if (id_two_src) srcs.push_back(int'(id_src2));
    window = enable_forward_unit ? 1 : 2;
    foreach (srcs[k]) begin
      if (srcs[k] == 0) continue;
      for (int st = 0; st < window; st++) begin
        if (writes(pipe[st]) && pipe[st].dest == srcs[k] &&
            (!enable_forward_unit || pipe[st].ld)) s = 1;
      end
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    m_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hazard_stall", 32'(hazard_stall), 32'(model_stall()));
    chk("exe_reg_dest", 32'(exe_reg_dest), pipe[0].dest);
    chk("exe_reg_wb",   32'(exe_reg_wb),   32'(writes(pipe[0])));
    chk("mem_reg_dest", 32'(mem_reg_dest), pipe[1].dest);
    chk("mem_reg_wb",   32'(mem_reg_wb),   32'(writes(pipe[1])));
    chk("wb_reg_dest",  32'(wb_reg_dest),  pipe[2].dest);
    chk("wb_reg_wb",    32'(wb_reg_wb),    32'(writes(pipe[2])));
    chk("stall_count",  32'(stall_count),  m_cnt);
  endtask

  // One clock: check at negedge, predict, commit the prediction after posedge.
  task automatic cycle();
    bit s;
    @(negedge clk);
    check_all();
    s = model_stall();
    n_cnt = m_cnt;
    for (int i = 0; i < 3; i++) nxt[i] = pipe[i];
    if (!rst) begin
      for (int i = 0; i < 3; i++) nxt[i] = '{0, 0, 0, 0};
      n_cnt = 0;
    end else if (!freeze) begin
      nxt[2] = pipe[1];
      nxt[1] = pipe[0];
      nxt[0] = (flush || s) ? '{0, 0, 0, 0}
                            : '{id_valid, int'(id_reg_dest), id_wb_en, id_mem_read};
      if (s) n_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) pipe[i] = nxt[i];
    m_cnt = n_cnt;
  endtask

  task automatic set_id(input bit v, input int s1, input int s2, input bit two,
                        input int d, input bit wb, input bit ld);
    id_valid    = v;
    id_src1     = REG_AW'(s1);
    id_src2     = REG_AW'(s2);
    id_two_src  = two;
    id_reg_dest = REG_AW'(d);
    id_wb_en    = wb;
    id_mem_read = ld;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
  endtask

  initial begin
    flush = 0;
    freeze = 0;
    enable_forward_unit = 1;
    set_id(1, 1, 2, 1, 3, 1, 0);
    rst = 0;
    model_reset();
    #2;

    // 1. reset with active ID inputs, then first instruction enters EXE
    repeat (3) cycle();
    chk("rst_stall", 32'(hazard_stall), 0);
    chk("rst_exe_wb", 32'(exe_reg_wb), 0);
    rst = 1;
    cycle();
    chk("first_exe_dest", 32'(exe_reg_dest), 3);
    chk("first_exe_wb", 32'(exe_reg_wb), 1);
    drain();

    // 2. load-use with forwarding
    set_id(1, 1, 0, 0, 5, 1, 1);
    cycle();
    set_id(1, 5, 1, 1, 6, 1, 0);
    #1 chk("lu_stall", 32'(hazard_stall), 1);
    cycle();
    chk("lu_release", 32'(hazard_stall), 0);
    chk("lu_bubble", 32'(exe_reg_wb), 0);
    chk("lu_mem_dest", 32'(mem_reg_dest), 5);
    chk("lu_mem_wb", 32'(mem_reg_wb), 1);
    chk("lu_count", 32'(stall_count), 1);
    cycle();
    drain();

    // 3. no forwarding: two stall cycles
    enable_forward_unit = 0;
    set_id(1, 1, 2, 1, 3, 1, 0);
    cycle();
    set_id(1, 3, 2, 1, 4, 1, 0);
    #1 chk("nf_stall1", 32'(hazard_stall), 1);
    cycle();
    chk("nf_stall2", 32'(hazard_stall), 1);
    cycle();
    chk("nf_release", 32'(hazard_stall), 0);
    chk("nf_wb_dest", 32'(wb_reg_dest), 3);
    cycle();
    drain();

    // 4. $0 sources and unused src2 never stall
    set_id(1, 1, 2, 1, 0, 1, 0);
    cycle();
    set_id(1, 0, 0, 1, 7, 1, 0);
    #1 chk("zero_src", 32'(hazard_stall), 0);
    cycle();
    set_id(1, 9, 7, 0, 8, 1, 0);
    #1 chk("src2_gated", 32'(hazard_stall), 0);
    cycle();
    drain();

    // 5. freeze during a load-use stall
    enable_forward_unit = 1;
    set_id(1, 1, 0, 0, 5, 1, 1);
    cycle();
    set_id(1, 5, 1, 1, 6, 1, 0);
    freeze = 1;
    repeat (6) begin
      cycle();
      chk("frz_stall", 32'(hazard_stall), 1);
      chk("frz_count", 32'(stall_count), 3);
      chk("frz_exe_dest", 32'(exe_reg_dest), 5);
    end
    freeze = 0;
    cycle();
    chk("frz_bubble", 32'(exe_reg_wb), 0);
    chk("frz_count_inc", 32'(stall_count), 4);
    cycle();
    drain();

    // 6. flush with valid ID, then counter saturation
    set_id(1, 1, 2, 1, 9, 1, 0);
    flush = 1;
    cycle();
    flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    chk("flush_bubble", 32'(exe_reg_wb), 0);
    enable_forward_unit = 0;
    set_id(1, 3, 3, 1, 3, 1, 0);
    repeat (40) cycle();
    chk("sat_count", 32'(stall_count), CMAX);
    repeat (6) cycle();
    chk("sat_hold", 32'(stall_count), CMAX);
    drain();

    // reset mid-stall drops the stall at once
    enable_forward_unit = 1;
    set_id(1, 1, 0, 0, 5, 1, 1);
    cycle();
    set_id(1, 5, 1, 1, 6, 1, 0);
    #1 chk("rms_stall", 32'(hazard_stall), 1);
    rst = 0;
    model_reset();
    #1 chk("rms_drop", 32'(hazard_stall), 0);
    chk("rms_exe_wb", 32'(exe_reg_wb), 0);
    chk("rms_count", 32'(stall_count), 0);
    cycle();
    rst = 1;

    // randomized traffic on a small register set to provoke hits
    for (int n = 0; n < 600; n++) begin
      set_id(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 4)), 1'($urandom), int'($urandom_range(0, 4)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      enable_forward_unit = 1'($urandom_range(0, 3) != 0);
      freeze = 1'($urandom_range(0, 5) == 0);
      flush  = 1'($urandom_range(0, 7) == 0);
      rst    = 1'($urandom_range(0, 60) != 0);
      if (!rst) model_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
